// File: rtl/mux_sel_pkg.sv
// Shared types and helpers for the project-select controller.
`timescale 1ns/1ps
package mux_sel_pkg;

    // Controller states: nothing selected, guard gap, settling, forwarding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFF    = 2'd1,
        ON     = 2'd2,
        ACTIVE = 2'd3
    } state_t;

    // Width of the shared guard/settle down-counter (never below 1 bit)
    function automatic int cnt_w(input int guard, input int settle);
        int m;
        m = (guard > settle) ? guard : settle;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mux_sel_onehot.sv
// Address to one-hot enable decoder with an enable gate and range check.
`timescale 1ns/1ps
module mux_sel_onehot #(
    parameter int NPROJ = 23,
    parameter int AW    = 5
) (
    input  logic             en,
    input  logic [AW-1:0]    addr,
    output logic [NPROJ-1:0] onehot,
    output logic             in_range
);

    // Decode the address; slots at or beyond NPROJ have no enable bit at all
    always_comb begin
        onehot   = '0;
        in_range = (int'(addr) < NPROJ);
        for (int k = 0; k < NPROJ; k++) begin
            onehot[k] = en && (int'(addr) == k);
        end
    end

endmodule

// File: rtl/mux_sel_ctrl.sv
// Break-before-make project select controller: drops all enables, waits a
// guard interval, enables the new project, lets it settle, then forwards
// its outputs through a register.
`timescale 1ns/1ps
module mux_sel_ctrl
    import mux_sel_pkg::*;
#(
    parameter int NPROJ  = 23,
    parameter int AW     = 5,
    parameter int IW     = 18,
    parameter int OW     = 24,
    parameter int GUARD  = 2,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel_valid,
    input  logic [AW-1:0]       sel_addr,
    output logic                sel_busy,
    output logic                sel_err,
    output logic                cur_valid,
    output logic [AW-1:0]       cur_addr,
    input  logic [IW-1:0]       iw,
    output logic [NPROJ-1:0]    proj_ena,
    output logic [IW-1:0]       proj_iw,
    input  logic [NPROJ*OW-1:0] proj_ow,
    output logic [OW-1:0]       ow
);

    localparam int CW = cnt_w(GUARD, SETTLE);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   tgt;
    logic            pend_vld;
    logic [AW-1:0]   pend_addr;
    logic            req;
    logic [AW-1:0]   req_addr;
    logic [AW-1:0]   dec_addr;
    logic            dec_en;
    logic            tgt_ok;
    logic [OW-1:0]   ow_sel;

    assign sel_busy  = (state == OFF) || (state == ON);
    assign cur_valid = (state == ACTIVE);
    assign dec_en    = (state == ON) || (state == ACTIVE);
    assign dec_addr  = (state == ACTIVE) ? cur_addr : tgt;
    assign proj_iw   = dec_en ? iw : '0;

    mux_sel_onehot #(
        .NPROJ (NPROJ),
        .AW    (AW)
    ) u_onehot (
        .en       (dec_en),
        .addr     (dec_addr),
        .onehot   (proj_ena),
        .in_range (tgt_ok)
    );

    // A fresh strobe takes precedence over an older stored request
    always_comb begin
        req      = sel_valid | pend_vld;
        req_addr = sel_valid ? sel_addr : pend_addr;
    end

    // Pick the selected project's output slice
    always_comb begin
        ow_sel = '0;
        for (int k = 0; k < NPROJ; k++) begin
            if (int'(cur_addr) == k) begin
                ow_sel = proj_ow[k*OW +: OW];
            end
        end
    end

    // Switching sequencer with registered ow, error pulse and pending slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tgt       <= '0;
            cur_addr  <= '0;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            sel_err   <= 1'b0;
            ow        <= '0;
        end else begin
            sel_err <= 1'b0;
            ow      <= '0;
            case (state)
                IDLE, ACTIVE: begin
                    pend_vld <= 1'b0;
                    if (state == ACTIVE) begin
                        ow <= ow_sel;
                    end
                    if (req && !(state == ACTIVE && req_addr == cur_addr)) begin
                        tgt   <= req_addr;
                        cnt   <= CW'(GUARD);
                        state <= OFF;
                        ow    <= '0;
                    end
                end
                OFF: begin
                    if (sel_valid) begin
                        pend_vld  <= 1'b1;
                        pend_addr <= sel_addr;
                    end
                    if (cnt == CW'(1)) begin
                        if (!tgt_ok) begin
                            sel_err <= 1'b1;
                            state   <= IDLE;
                        end else if (SETTLE == 0) begin
                            cur_addr <= tgt;
                            state    <= ACTIVE;
                        end else begin
                            cnt   <= CW'(SETTLE);
                            state <= ON;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ON: begin
                    if (sel_valid) begin
                        pend_vld  <= 1'b1;
                        pend_addr <= sel_addr;
                    end
                    if (cnt == CW'(1)) begin
                        cur_addr <= tgt;
                        state    <= ACTIVE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed bench for mux_sel_ctrl with hand-computed expectations.
`timescale 1ns/1ps
module tb_mux_sel_ctrl;

    localparam int NPROJ  = 23;
    localparam int AW     = 5;
    localparam int IW     = 18;
    localparam int OW     = 24;
    localparam int GUARD  = 2;
    localparam int SETTLE = 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                sel_valid;
    logic [AW-1:0]       sel_addr;
    logic                sel_busy;
    logic                sel_err;
    logic                cur_valid;
    logic [AW-1:0]       cur_addr;
    logic [IW-1:0]       iw;
    logic [NPROJ-1:0]    proj_ena;
    logic [IW-1:0]       proj_iw;
    logic [NPROJ*OW-1:0] proj_ow;
    logic [OW-1:0]       ow;

    int n_chk  = 0;
    int n_fail = 0;

    mux_sel_ctrl #(
        .NPROJ  (NPROJ),
        .AW     (AW),
        .IW     (IW),
        .OW     (OW),
        .GUARD  (GUARD),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel_valid (sel_valid),
        .sel_addr  (sel_addr),
        .sel_busy  (sel_busy),
        .sel_err   (sel_err),
        .cur_valid (cur_valid),
        .cur_addr  (cur_addr),
        .iw        (iw),
        .proj_ena  (proj_ena),
        .proj_iw   (proj_iw),
        .proj_ow   (proj_ow),
        .ow        (ow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        sel_valid = 1'b0;
        sel_addr  = '0;
        iw        = 18'h2A5A5;
        for (int k = 0; k < NPROJ; k++) begin
            proj_ow[k*OW +: OW] = {8'(k), 16'hC0DE};
        end
        proj_ow[3*OW +: OW] = 24'hABCDEF;

        tick();
        tick();
        check("rst_ena",   64'(proj_ena),  64'h0);
        check("rst_ow",    64'(ow),        64'h0);
        check("rst_busy",  64'(sel_busy),  64'h0);
        check("rst_err",   64'(sel_err),   64'h0);
        check("rst_cv",    64'(cur_valid), 64'h0);
        check("rst_addr",  64'(cur_addr),  64'h0);
        check("rst_iw",    64'(proj_iw),   64'h0);
        rst = 1'b0;
        tick();

        // select slot 3 from IDLE
        sel_valid = 1'b1; sel_addr = 5'd3;
        tick();
        sel_valid = 1'b0;
        check("s3_off1_busy", 64'(sel_busy), 64'h1);
        check("s3_off1_ena",  64'(proj_ena), 64'h0);
        check("s3_off1_iw",   64'(proj_iw),  64'h0);
        tick();
        check("s3_off2_ena",  64'(proj_ena), 64'h0);
        check("s3_off2_busy", 64'(sel_busy), 64'h1);
        tick();
        check("s3_on_ena",    64'(proj_ena),  64'h8);
        check("s3_on_iw",     64'(proj_iw),   64'h2A5A5);
        check("s3_on_ow",     64'(ow),        64'h0);
        check("s3_on_cv",     64'(cur_valid), 64'h0);
        tick();
        check("s3_act_cv",    64'(cur_valid), 64'h1);
        check("s3_act_busy",  64'(sel_busy),  64'h0);
        check("s3_act_addr",  64'(cur_addr),  64'h3);
        check("s3_act_ow0",   64'(ow),        64'h0);
        tick();
        check("s3_ow",        64'(ow),        64'hABCDEF);

        // switch 3 -> 7
        sel_valid = 1'b1; sel_addr = 5'd7;
        tick();
        sel_valid = 1'b0;
        check("s7_off1_ena",  64'(proj_ena), 64'h0);
        check("s7_off1_ow",   64'(ow),       64'h0);
        tick();
        check("s7_off2_ena",  64'(proj_ena), 64'h0);
        check("s7_off2_ow",   64'(ow),       64'h0);
        tick();
        check("s7_on_ena",    64'(proj_ena), 64'h80);
        check("s7_on_ow",     64'(ow),       64'h0);
        tick();
        check("s7_act_addr",  64'(cur_addr), 64'h7);
        check("s7_act_ow0",   64'(ow),       64'h0);
        check("s7_act_ena",   64'(proj_ena), 64'h80);
        tick();
        check("s7_ow",        64'(ow),       64'h07C0DE);

        // re-select current address 7: no effect
        sel_valid = 1'b1; sel_addr = 5'd7;
        tick();
        sel_valid = 1'b0;
        check("re7_busy",     64'(sel_busy), 64'h0);
        check("re7_ena",      64'(proj_ena), 64'h80);
        check("re7_ow",       64'(ow),       64'h07C0DE);
        tick();
        check("re7_busy2",    64'(sel_busy), 64'h0);
        check("re7_ow2",      64'(ow),       64'h07C0DE);

        // out-of-range address 25
        sel_valid = 1'b1; sel_addr = 5'd25;
        tick();
        sel_valid = 1'b0;
        check("oor_off1_ena", 64'(proj_ena),  64'h0);
        check("oor_off1_cv",  64'(cur_valid), 64'h0);
        check("oor_off1_err", 64'(sel_err),   64'h0);
        tick();
        check("oor_off2_ena", 64'(proj_ena),  64'h0);
        tick();
        check("oor_err",      64'(sel_err),   64'h1);
        check("oor_busy",     64'(sel_busy),  64'h0);
        check("oor_cv",       64'(cur_valid), 64'h0);
        check("oor_ena",      64'(proj_ena),  64'h0);
        check("oor_addr",     64'(cur_addr),  64'h7);
        check("oor_ow",       64'(ow),        64'h0);
        tick();
        check("oor_err_end",  64'(sel_err),   64'h0);
        check("oor_ena2",     64'(proj_ena),  64'h0);

        // select 2, then 5 and 9 while busy: last wins
        sel_valid = 1'b1; sel_addr = 5'd2;
        tick();
        sel_addr = 5'd5;
        tick();
        sel_addr = 5'd9;
        check("pnd_off_ena",  64'(proj_ena), 64'h0);
        tick();
        sel_valid = 1'b0;
        check("pnd_on_ena",   64'(proj_ena), 64'h4);
        tick();
        check("pnd_act_addr", 64'(cur_addr), 64'h2);
        check("pnd_act_busy", 64'(sel_busy), 64'h0);
        check("pnd_act_ena",  64'(proj_ena), 64'h4);
        tick();
        check("pnd_off1_busy", 64'(sel_busy), 64'h1);
        check("pnd_off1_ena",  64'(proj_ena), 64'h0);
        tick();
        check("pnd_off2_ena",  64'(proj_ena), 64'h0);
        tick();
        check("pnd_on9_ena",   64'(proj_ena), 64'h200);
        tick();
        check("pnd_act9_addr", 64'(cur_addr), 64'h9);
        check("pnd_act9_busy", 64'(sel_busy), 64'h0);
        tick();
        check("pnd_ow9",       64'(ow),       64'h09C0DE);
        check("pnd_no5",       64'(proj_ena[5]), 64'h0);
        tick();
        check("pnd_once_busy", 64'(sel_busy), 64'h0);
        check("pnd_once_addr", 64'(cur_addr), 64'h9);

        // async reset during ON, with a pending request stored
        sel_valid = 1'b1; sel_addr = 5'd1;
        tick();
        sel_addr = 5'd4;
        tick();
        sel_valid = 1'b0;
        tick();
        check("ar_on_ena",    64'(proj_ena), 64'h2);
        #3;
        rst = 1'b1;
        #1;
        check("ar_ena",       64'(proj_ena),  64'h0);
        check("ar_busy",      64'(sel_busy),  64'h0);
        check("ar_ow",        64'(ow),        64'h0);
        check("ar_cv",        64'(cur_valid), 64'h0);
        check("ar_iw",        64'(proj_iw),   64'h0);
        tick();
        rst = 1'b0;
        tick();
        check("ar_pend_busy", 64'(sel_busy),  64'h0);
        check("ar_pend_ena",  64'(proj_ena),  64'h0);

        // fresh request after reset takes the full sequence
        sel_valid = 1'b1; sel_addr = 5'd6;
        tick();
        sel_valid = 1'b0;
        check("fr_off1_busy", 64'(sel_busy), 64'h1);
        check("fr_off1_ena",  64'(proj_ena), 64'h0);
        tick();
        check("fr_off2_ena",  64'(proj_ena), 64'h0);
        tick();
        check("fr_on_ena",    64'(proj_ena), 64'h40);
        tick();
        check("fr_act_addr",  64'(cur_addr),  64'h6);
        check("fr_act_cv",    64'(cur_valid), 64'h1);
        tick();
        check("fr_ow",        64'(ow),        64'h06C0DE);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // Break-before-make invariant: never more than one enable bit
    always @(negedge clk) begin
        if (!rst) begin
            check("onehot_inv", 64'($countones(proj_ena) <= 1), 64'h1);
        end
    end

endmodule
